// File: rtl/jtframe_neptuno_joyscan.sv
// Scan controller for the Neptuno 74HC165 joystick chain: drives LOAD/CLK/SEL and publishes active-low pad words.
// Define JTFRAME_JOYSCAN_MD6_EN to scan 8 sub-scans per frame and decode Mega Drive 6-button pads.
module jtframe_neptuno_joyscan #(
  parameter int CLK_DIV   = 4,
  parameter int SEL_TICKS = 8,
  parameter int FRAME_GAP = 2048
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        intercept,
  input  logic        joy_data_i,
  output logic        joy_clk_o,
  output logic        joy_load_o,
  output logic        joy_sel_o,
  output logic [11:0] joy1_o,
  output logic [11:0] joy2_o,
  output logic        six1_o,
  output logic        six2_o,
  output logic        frame_o
);

`ifdef JTFRAME_JOYSCAN_MD6_EN
  localparam logic [2:0] LAST_SUB = 3'd7;
`else
  localparam logic [2:0] LAST_SUB = 3'd0;
`endif

  localparam int PW = (CLK_DIV > 2) ? $clog2(CLK_DIV) : 1;
  localparam int CW = 16;

  typedef enum logic [2:0] {ST_GAP, ST_LOAD, ST_SHIFT, ST_LATCH, ST_SEL} state_t;

  state_t          state;
  logic [PW-1:0]   presc;
  logic            tick;
  logic [CW-1:0]   cnt;
  logic [2:0]      sub;
  logic [15:0]     sreg;
  logic [7:0]      raw1_q, raw2_q, raw1_n, raw2_n;
  logic [11:0]     joy1_q, joy2_q, joy1_n, joy2_n;
  logic            six1_n, six2_n;
`ifdef JTFRAME_JOYSCAN_MD6_EN
  logic            det1_q, det2_q, det1_n, det2_n;
  logic [3:0]      ext1_q, ext2_q, ext1_n, ext2_n;
`endif

  // Raw byte is up..start from MSB down; pad word is up..start from LSB up.
  function automatic logic [7:0] remap(input logic [7:0] r);
    logic [7:0] w;
    for (int i = 0; i < 8; i++) w[i] = r[7-i];
    return w;
  endfunction

  assign tick = (presc == PW'(CLK_DIV - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) presc <= '0;
    else        presc <= tick ? '0 : presc + 1'b1;
  end

  // Values as they will stand after the current LATCH, so the last sub-scan can publish in the same clock.
  always_comb begin
    raw1_n = (sub == 3'd0) ? sreg[15:8] : raw1_q;
    raw2_n = (sub == 3'd0) ? sreg[7:0]  : raw2_q;
`ifdef JTFRAME_JOYSCAN_MD6_EN
    det1_n = (sub == 3'd5) ? (sreg[15:12] == 4'd0) : det1_q;
    det2_n = (sub == 3'd5) ? (sreg[7:4]   == 4'd0) : det2_q;
    ext1_n = (sub == 3'd6) ? sreg[15:12] : ext1_q;
    ext2_n = (sub == 3'd6) ? sreg[7:4]   : ext2_q;
    six1_n = det1_n;
    six2_n = det2_n;
    joy1_n = {det1_n ? {ext1_n[0], ext1_n[3], ext1_n[2], ext1_n[1]} : 4'hF, remap(raw1_n)};
    joy2_n = {det2_n ? {ext2_n[0], ext2_n[3], ext2_n[2], ext2_n[1]} : 4'hF, remap(raw2_n)};
`else
    six1_n = 1'b0;
    six2_n = 1'b0;
    joy1_n = {4'hF, remap(raw1_n)};
    joy2_n = {4'hF, remap(raw2_n)};
`endif
  end

  // Scan sequencer: GAP -> LOAD -> SHIFT -> LATCH -> (SEL -> LOAD | GAP).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= ST_GAP;
      cnt        <= '0;
      sub        <= 3'd0;
      sreg       <= 16'd0;
      raw1_q     <= 8'hFF;
      raw2_q     <= 8'hFF;
`ifdef JTFRAME_JOYSCAN_MD6_EN
      det1_q     <= 1'b0;
      det2_q     <= 1'b0;
      ext1_q     <= 4'hF;
      ext2_q     <= 4'hF;
`endif
      joy1_q     <= 12'hFFF;
      joy2_q     <= 12'hFFF;
      six1_o     <= 1'b0;
      six2_o     <= 1'b0;
      frame_o    <= 1'b0;
      joy_clk_o  <= 1'b0;
      joy_load_o <= 1'b1;
      joy_sel_o  <= 1'b1;
    end else begin
      frame_o <= 1'b0;
      case (state)
        ST_GAP: begin
          joy_sel_o <= 1'b1;
          sub       <= 3'd0;
          if (tick) begin
            if (cnt == CW'(FRAME_GAP - 1)) begin
              cnt        <= '0;
              joy_load_o <= 1'b0;
              state      <= ST_LOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_LOAD: begin
          joy_clk_o <= 1'b0;
          if (tick) begin
            joy_load_o <= 1'b1;
            cnt        <= '0;
            state      <= ST_SHIFT;
          end
        end
        ST_SHIFT: begin
          if (tick) begin
            if (!cnt[0]) begin
              sreg      <= {sreg[14:0], joy_data_i};
              joy_clk_o <= 1'b1;
            end else begin
              joy_clk_o <= 1'b0;
            end
            if (cnt == CW'(31)) begin
              cnt   <= '0;
              state <= ST_LATCH;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        ST_LATCH: begin
          raw1_q <= raw1_n;
          raw2_q <= raw2_n;
`ifdef JTFRAME_JOYSCAN_MD6_EN
          det1_q <= det1_n;
          det2_q <= det2_n;
          ext1_q <= ext1_n;
          ext2_q <= ext2_n;
`endif
          sub <= sub + 1'b1;
          cnt <= '0;
          if (sub == LAST_SUB) begin
            joy1_q    <= joy1_n;
            joy2_q    <= joy2_n;
            six1_o    <= six1_n;
            six2_o    <= six2_n;
            frame_o   <= 1'b1;
            joy_sel_o <= 1'b1;
            state     <= ST_GAP;
          end else begin
            joy_sel_o <= ~joy_sel_o;
            state     <= ST_SEL;
          end
        end
        ST_SEL: begin
          if (tick) begin
            if (cnt == CW'(SEL_TICKS - 1)) begin
              cnt        <= '0;
              joy_load_o <= 1'b0;
              state      <= ST_LOAD;
            end else begin
              cnt <= cnt + 1'b1;
            end
          end
        end
        default: state <= ST_GAP;
      endcase
    end
  end

  // OSD masking is purely combinational so the real state reappears without a clock of delay.
  assign joy1_o = intercept ? 12'hFFF : joy1_q;
  assign joy2_o = intercept ? 12'hFFF : joy2_q;

endmodule

// File: tb/tb_jtframe_neptuno_joyscan.sv
// Directed-vector bench for jtframe_neptuno_joyscan with a behavioural 74HC165 chain model.
// Honours JTFRAME_JOYSCAN_MD6_EN to add the 6-button decode sequence.
module tb_jtframe_neptuno_joyscan;

`ifdef JTFRAME_JOYSCAN_MD6_EN
  localparam int SUBS = 8;
`else
  localparam int SUBS = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        intercept = 1'b0;
  logic        joy_data_i;
  logic        joy_clk_o, joy_load_o, joy_sel_o;
  logic [11:0] joy1_o, joy2_o;
  logic        six1_o, six2_o, frame_o;

  int nCmp = 0;
  int nBad = 0;
  int selLow = 0;

  logic [15:0] subFrames [8];
  logic [15:0] chain = 16'hFFFF;
  int          ldIdx = 0;

  jtframe_neptuno_joyscan #(.CLK_DIV(4), .SEL_TICKS(2), .FRAME_GAP(4)) dut (
    .clk(clk), .rst_n(rst_n), .intercept(intercept), .joy_data_i(joy_data_i),
    .joy_clk_o(joy_clk_o), .joy_load_o(joy_load_o), .joy_sel_o(joy_sel_o),
    .joy1_o(joy1_o), .joy2_o(joy2_o), .six1_o(six1_o), .six2_o(six2_o), .frame_o(frame_o)
  );

  always #5 clk = ~clk;

  // Shift-register chain: parallel load on LOAD low, shift toward Q7 on each CLK rising edge.
  always @(negedge joy_load_o or posedge joy_clk_o or negedge rst_n) begin
    if (!rst_n) begin
      ldIdx = 0;
      chain = 16'hFFFF;
    end else if (!joy_load_o) begin
      chain = subFrames[ldIdx];
      ldIdx = (ldIdx + 1) % SUBS;
    end else begin
      chain = {chain[14:0], 1'b1};
    end
  end
  assign joy_data_i = chain[15];

  always @(negedge clk) if (rst_n && !joy_sel_o) selLow++;

  typedef struct {
    logic [15:0] frame;
    logic        icpt;
    logic [11:0] j1;
    logic [11:0] j2;
  } vec_t;

  vec_t vecs [7];

  task automatic checkOutput(input string name, input logic [11:0] act, input logic [11:0] exp);
    nCmp++;
    if (act !== exp) begin
      nBad++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic [15:0] frame, input logic icpt);
    subFrames[0] = frame;
    intercept    = icpt;
  endtask

  task automatic waitFrame(output int cyc);
    logic seen;
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 3000) begin
      @(negedge clk);
      cyc++;
      if (frame_o) seen = 1'b1;
    end
    checkOutput("frame_seen", 12'(seen), 12'd1);
  endtask

  initial begin
    int cyc, n, bad, hi, lo, rises;
    logic prev;
    logic [11:0] e1, e2;

    for (int i = 0; i < 8; i++) subFrames[i] = 16'hFFFF;
    vecs[0] = '{16'h7FFE, 1'b0, 12'hFFE, 12'hF7F};
    vecs[1] = '{16'h7FFE, 1'b1, 12'hFFE, 12'hF7F};
    vecs[2] = '{16'hFFFF, 1'b0, 12'hFFF, 12'hFFF};
    vecs[3] = '{16'h0000, 1'b0, 12'hF00, 12'hF00};
    vecs[4] = '{16'h801F, 1'b0, 12'hF01, 12'hFF8};
    vecs[5] = '{16'hFE01, 1'b1, 12'hF7F, 12'hF80};
    vecs[6] = '{16'h0000, 1'b0, 12'hF00, 12'hF00};

    repeat (3) @(negedge clk);
    checkOutput("rst_load", 12'(joy_load_o), 12'd1);
    checkOutput("rst_sel",  12'(joy_sel_o),  12'd1);
    checkOutput("rst_clk",  12'(joy_clk_o),  12'd0);
    checkOutput("rst_joy1", joy1_o, 12'hFFF);
    checkOutput("rst_joy2", joy2_o, 12'hFFF);
    checkOutput("rst_frame", 12'(frame_o), 12'd0);
    checkOutput("rst_six", {10'd0, six2_o, six1_o}, 12'd0);

    applyStimulus(vecs[0].frame, vecs[0].icpt);
    rst_n = 1'b1;

    n = 0;
    while (joy_load_o && n < 100) begin @(negedge clk); n++; end
    n = 0;
    while (!joy_load_o && n < 100) begin @(negedge clk); n++; end
    checkOutput("load_width", 12'(n), 12'd4);

    bad = 0;
    for (int p = 0; p < 16; p++) begin
      n = 0;
      while (!joy_clk_o && n < 20) begin @(negedge clk); n++; end
      hi = 0;
      while (joy_clk_o && hi < 20) begin @(negedge clk); hi++; end
      if (hi != 4) bad++;
      if (p < 15) begin
        lo = 1;
        while (!joy_clk_o && lo < 20) begin @(negedge clk); if (!joy_clk_o) lo++; end
        if (lo != 4) bad++;
      end
    end
    checkOutput("clk_pulses", 12'(bad), 12'd0);

    for (int v = 0; v < 7; v++) begin
      applyStimulus(vecs[v].frame, vecs[v].icpt);
      waitFrame(cyc);
      e1 = vecs[v].icpt ? 12'hFFF : vecs[v].j1;
      e2 = vecs[v].icpt ? 12'hFFF : vecs[v].j2;
      checkOutput($sformatf("v%0d_joy1", v), joy1_o, e1);
      checkOutput($sformatf("v%0d_joy2", v), joy2_o, e2);
      checkOutput($sformatf("v%0d_six", v), {10'd0, six2_o, six1_o}, 12'd0);
      @(negedge clk);
      checkOutput($sformatf("v%0d_pulse", v), 12'(frame_o), 12'd0);
      if (vecs[v].icpt) begin
        intercept = 1'b0;
        #1;
        checkOutput($sformatf("v%0d_drop1", v), joy1_o, vecs[v].j1);
        checkOutput($sformatf("v%0d_drop2", v), joy2_o, vecs[v].j2);
      end
    end

    // Abort a frame at shift bit 9; the partial data must never surface.
    applyStimulus(16'hFFFF, 1'b0);
    n = 0;
    while (joy_load_o && n < 3000) begin @(negedge clk); n++; end
    rises = 0; prev = joy_clk_o; n = 0;
    while (rises < 10 && n < 300) begin
      @(negedge clk); n++;
      if (joy_clk_o && !prev) rises++;
      prev = joy_clk_o;
    end
    checkOutput("abort_reached", 12'(rises), 12'd10);
    rst_n = 1'b0;
    #1;
    checkOutput("abort_joy1", joy1_o, 12'hFFF);
    checkOutput("abort_joy2", joy2_o, 12'hFFF);
    checkOutput("abort_load", 12'(joy_load_o), 12'd1);
    checkOutput("abort_clk",  12'(joy_clk_o),  12'd0);
    applyStimulus(16'h7FFE, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    waitFrame(cyc);
    checkOutput("clean_full_frame", 12'(cyc > 140), 12'd1);
    checkOutput("clean_joy1", joy1_o, 12'hFFE);
    checkOutput("clean_joy2", joy2_o, 12'hF7F);

`ifdef JTFRAME_JOYSCAN_MD6_EN
    subFrames[0] = 16'hFFFF;
    subFrames[5] = 16'h0FFF;
    subFrames[6] = 16'h7FFF;
    waitFrame(cyc);
    waitFrame(cyc);
    checkOutput("md6_six1", 12'(six1_o), 12'd1);
    checkOutput("md6_six2", 12'(six2_o), 12'd0);
    checkOutput("md6_joy1", joy1_o, 12'hBFF);
    checkOutput("md6_joy2", joy2_o, 12'hFFF);
`else
    checkOutput("sel_const", 12'(selLow), 12'd0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nBad);
    $finish;
  end

endmodule
